abs_sum_window_detector: RTL and testbench
==========================================

Name: abs_sum_window_detector

Overview:
- Sequential stage directly downstream of the 16-lane absolute-sum tree in the detection path.
- Consumes one per-period absolute sum per valid beat and accumulates WINDOW_LEN periods into a window energy.
- Compares each window energy against a programmable threshold and runs a hit/miss hysteresis state machine that drives the detection flag consumed by the eval control logic.

Parameters:
- WINDOW_LEN, 64, number of accepted periods per window (>=1)
- DETECT_COUNT, 3, consecutive above-threshold windows needed to assert detection (>=1)
- RELEASE_COUNT, 2, consecutive below-threshold windows needed to release detection (>=1)
- SUM_W, 12, width of the per-period abs sum; max 16*128 = 2048 fits unsigned 12 bits
- ACC_W, 32, window accumulator / WindowSum width, signed

Ports:
- clk  in  1  system clock; all logic rising-edge
- rst  in  1  synchronous reset, active-high
- Enable  in  1  1 = accept PeriodValid; 0 = hold all state
- Clear  in  1  synchronous soft clear, single cycle
- PeriodValid  in  1  PeriodAbsSum valid this cycle
- PeriodAbsSum  in  SUM_W  unsigned abs sum of one 16-sample period
- Threshold  in  ACC_W  signed window threshold, sampled at window completion
- WindowValid  out  1  one-cycle pulse: WindowSum and AboveThr are valid
- WindowSum  out  ACC_W  completed window energy, signed, non-negative
- AboveThr  out  1  WindowSum >= Threshold for this window
- Detected  out  1  level detection flag
- DetectPulse  out  1  one-cycle pulse on the Detected 0->1 transition
- PeriodCount  out  clog2(WINDOW_LEN)+1  periods accepted in the current window

Behaviour:
- Reset (rst=1 at an edge): accumulator=0, PeriodCount=0, HitCnt=0, MissCnt=0, state IDLE. All outputs are 0.
- Priority per cycle: rst > Clear > Enable gating > PeriodValid.
- Clear: same effect as reset on all state and outputs. A PeriodValid in the same cycle is dropped.
- Accept: an accepted beat is PeriodValid=1 with Enable=1 and Clear=0. Any other cycle leaves every register unchanged and forces both pulses to 0.
- Arithmetic: PeriodAbsSum is zero-extended to ACC_W and added to the accumulator. The sum saturates at 2^(ACC_W-1)-1 and never wraps negative.
- Window completion (accepted beat with PeriodCount == WINDOW_LEN-1):
  - On the next edge, WindowSum = saturated acc+PeriodAbsSum, WindowValid=1, AboveThr = (WindowSum >= Threshold), signed compare.
  - Latency is 1 cycle from the final beat.
  - Accumulator and PeriodCount return to 0 on the same edge, so the next beat starts a new window with no gap.
- Non-completing accepted beat: acc += PeriodAbsSum, PeriodCount++. WindowValid=0.
- WindowSum and AboveThr hold their last values between windows.
- FSM, updated on window completion only; Detected and DetectPulse are registered in the same cycle as WindowValid:
  - IDLE, above: HitCnt++. If HitCnt reaches DETECT_COUNT, go to ACTIVE, Detected=1, DetectPulse=1, HitCnt=0.
  - IDLE, below: HitCnt=0.
  - ACTIVE, below: MissCnt++. If MissCnt reaches RELEASE_COUNT, go to IDLE, Detected=0, MissCnt=0.
  - ACTIVE, above: MissCnt=0.
- DETECT_COUNT=1: a single above-threshold window asserts detection. RELEASE_COUNT=1 behaves the same way for release.
- Threshold <= 0: every window counts as above.
- Threshold changes mid-window: only the value at the completion edge matters.
- rst or Clear while ACTIVE: Detected drops to 0 on that edge with no DetectPulse. The partial window is discarded.

Test Plan:
- WINDOW_LEN=4; 4 consecutive beats of 100, Threshold=500 -> one cycle after beat 4: WindowValid=1, WindowSum=400, AboveThr=0, Detected=0. PeriodCount goes 1,2,3,0.
- WINDOW_LEN=4, DETECT_COUNT=3; three windows of 4x200, Threshold=500 -> AboveThr=1 each. Detected and DetectPulse rise with the 3rd WindowValid, pulse lasts 1 cycle.
- ACTIVE, RELEASE_COUNT=2; windows below, above, below, below -> MissCnt resets after the above window. Detected falls at the 4th window only.
- Bubbles: beats interleaved with PeriodValid=0 and Enable=0 cycles carrying nonzero PeriodAbsSum -> WindowSum equals the sum of accepted beats only.
- Clear asserted together with the 3rd beat of a window, while ACTIVE -> beat dropped, Detected=0 with no pulse. The next 4 beats of 50 give WindowSum=200.
- ACC_W=16, WINDOW_LEN=32; beats of 2048 -> WindowSum saturates at 32767 and stays positive. AboveThr=1 for Threshold=32767.

Source files
------------

// File: rtl/abs_sum_window_detector.sv
// -----------------------------------------------------------------------------
// abs_sum_window_detector
//
// Sits right after the 16-lane absolute-sum tree. Each accepted beat adds one
// per-period absolute sum to a window accumulator. After WINDOW_LEN accepted
// periods the window energy is published and compared against Threshold. A
// hit/miss hysteresis FSM turns the stream of per-window comparisons into a
// level Detected flag plus a one-cycle DetectPulse on its rising edge.
//
// Ports
//   clk           system clock, rising edge
//   rst           synchronous reset, active high
//   Enable        1 = beats may be accepted, 0 = hold every register
//   Clear         synchronous soft clear, same effect as rst
//   PeriodValid   PeriodAbsSum is valid this cycle
//   PeriodAbsSum  unsigned absolute sum of one 16-sample period
//   Threshold     signed window threshold, sampled at window completion
//   WindowValid   one-cycle pulse, WindowSum/AboveThr refreshed
//   WindowSum     completed window energy (signed, never negative)
//   AboveThr      WindowSum >= Threshold for the last completed window
//   Detected      level detection flag
//   DetectPulse   one-cycle pulse on Detected 0->1
//   PeriodCount   periods accepted so far in the current window
//
// FSM states
//   state  | meaning
//   IDLE   | not detected; counting consecutive above-threshold windows
//   ACTIVE | detected; counting consecutive below-threshold windows
// -----------------------------------------------------------------------------
module abs_sum_window_detector #(
  parameter int WINDOW_LEN    = 64,
  parameter int DETECT_COUNT  = 3,
  parameter int RELEASE_COUNT = 2,
  parameter int SUM_W         = 12,
  parameter int ACC_W         = 32,
  localparam int CNT_W        = $clog2(WINDOW_LEN) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    Enable,
  input  logic                    Clear,
  input  logic                    PeriodValid,
  input  logic        [SUM_W-1:0] PeriodAbsSum,
  input  logic signed [ACC_W-1:0] Threshold,
  output logic                    WindowValid,
  output logic signed [ACC_W-1:0] WindowSum,
  output logic                    AboveThr,
  output logic                    Detected,
  output logic                    DetectPulse,
  output logic        [CNT_W-1:0] PeriodCount
);

  localparam int HIT_W  = $clog2(DETECT_COUNT + 1);
  localparam int MISS_W = $clog2(RELEASE_COUNT + 1);

  // Largest positive value of a signed ACC_W word.
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t            state;
  logic [ACC_W-1:0]  acc;
  logic [HIT_W-1:0]  hit_cnt;
  logic [MISS_W-1:0] miss_cnt;

  logic              accept;
  logic              last_beat;
  logic [ACC_W:0]    sum_raw;
  logic [ACC_W-1:0]  sum_sat;
  logic              above_now;

  assign accept    = Enable & PeriodValid & ~Clear;
  assign last_beat = (PeriodCount == CNT_W'(WINDOW_LEN - 1));

  // The accumulator is always non-negative, so one extra bit holds the raw
  // sum exactly; clamping it to ACC_MAX keeps the signed result positive.
  assign sum_raw   = {1'b0, acc} + {{(ACC_W + 1 - SUM_W){1'b0}}, PeriodAbsSum};
  assign sum_sat   = (sum_raw > {1'b0, ACC_MAX}) ? ACC_MAX : sum_raw[ACC_W-1:0];
  assign above_now = ($signed(sum_sat) >= Threshold);

  always_ff @(posedge clk) begin
    if (rst || Clear) begin
      state       <= IDLE;
      acc         <= '0;
      PeriodCount <= '0;
      hit_cnt     <= '0;
      miss_cnt    <= '0;
      WindowValid <= 1'b0;
      WindowSum   <= '0;
      AboveThr    <= 1'b0;
      Detected    <= 1'b0;
      DetectPulse <= 1'b0;
    end else begin
      WindowValid <= 1'b0;
      DetectPulse <= 1'b0;
      if (accept) begin
        if (last_beat) begin
          // Close the window and restart on the same edge: no gap beat.
          acc         <= '0;
          PeriodCount <= '0;
          WindowSum   <= sum_sat;
          AboveThr    <= above_now;
          WindowValid <= 1'b1;
          case (state)
            IDLE: begin
              if (above_now) begin
                if (hit_cnt == HIT_W'(DETECT_COUNT - 1)) begin
                  state       <= ACTIVE;
                  Detected    <= 1'b1;
                  DetectPulse <= 1'b1;
                  hit_cnt     <= '0;
                end else begin
                  hit_cnt <= hit_cnt + 1'b1;
                end
              end else begin
                hit_cnt <= '0;
              end
            end
            ACTIVE: begin
              if (!above_now) begin
                if (miss_cnt == MISS_W'(RELEASE_COUNT - 1)) begin
                  state    <= IDLE;
                  Detected <= 1'b0;
                  miss_cnt <= '0;
                end else begin
                  miss_cnt <= miss_cnt + 1'b1;
                end
              end else begin
                miss_cnt <= '0;
              end
            end
            default: begin
              state <= IDLE;
            end
          endcase
        end else begin
          acc         <= sum_sat;
          PeriodCount <= PeriodCount + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_abs_sum_window_detector.sv
module tb_abs_sum_window_detector;

  logic clk;
  logic rst;
  logic en;
  logic clr;
  logic pv;
  logic [11:0] abs_sum;
  logic signed [31:0] thr32;
  logic signed [15:0] thr16;

  logic wv0, ab0, det0, dp0;
  logic signed [31:0] ws0;
  logic [2:0] pc0;
  logic wv1, ab1, det1, dp1;
  logic signed [15:0] ws1;
  logic [5:0] pc1;

  int checks = 0;
  int errors = 0;

  // instance 0: short windows, 3-hit / 2-miss hysteresis
  abs_sum_window_detector #(
    .WINDOW_LEN(4), .DETECT_COUNT(3), .RELEASE_COUNT(2), .SUM_W(12), .ACC_W(32)
  ) dut0 (
    .clk(clk), .rst(rst), .Enable(en), .Clear(clr), .PeriodValid(pv),
    .PeriodAbsSum(abs_sum), .Threshold(thr32),
    .WindowValid(wv0), .WindowSum(ws0), .AboveThr(ab0),
    .Detected(det0), .DetectPulse(dp0), .PeriodCount(pc0)
  );

  // instance 1: narrow accumulator that saturates, single-window hysteresis
  abs_sum_window_detector #(
    .WINDOW_LEN(32), .DETECT_COUNT(1), .RELEASE_COUNT(1), .SUM_W(12), .ACC_W(16)
  ) dut1 (
    .clk(clk), .rst(rst), .Enable(en), .Clear(clr), .PeriodValid(pv),
    .PeriodAbsSum(abs_sum), .Threshold(thr16),
    .WindowValid(wv1), .WindowSum(ws1), .AboveThr(ab1),
    .Detected(det1), .DetectPulse(dp1), .PeriodCount(pc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: plain window sum, clamp at the end, run-length hysteresis
  longint wl [2] = '{4, 32};
  int     dc [2] = '{3, 1};
  int     rc [2] = '{2, 1};
  longint mx [2] = '{64'd2147483647, 64'd32767};

  longint m_acc  [2];
  int     m_cnt  [2];
  int     m_hit  [2];
  int     m_miss [2];
  bit     m_det  [2];
  bit     m_pulse[2];
  bit     m_wv   [2];
  bit     m_above[2];
  longint m_ws   [2];

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_edge(input int i, input longint thr);
    longint s;
    m_wv[i]    = 1'b0;
    m_pulse[i] = 1'b0;
    if (rst || clr) begin
      m_acc[i] = 0; m_cnt[i] = 0; m_hit[i] = 0; m_miss[i] = 0;
      m_det[i] = 1'b0; m_above[i] = 1'b0; m_ws[i] = 0;
    end else if (en && pv) begin
      s = m_acc[i] + longint'(abs_sum);
      m_cnt[i]++;
      if (m_cnt[i] == wl[i]) begin
        m_ws[i]    = (s > mx[i]) ? mx[i] : s;
        m_above[i] = (m_ws[i] >= thr);
        m_wv[i]    = 1'b1;
        m_acc[i]   = 0;
        m_cnt[i]   = 0;
        if (!m_det[i]) begin
          m_hit[i] = m_above[i] ? m_hit[i] + 1 : 0;
          if (m_hit[i] == dc[i]) begin
            m_det[i] = 1'b1; m_pulse[i] = 1'b1; m_hit[i] = 0;
          end
        end else begin
          m_miss[i] = m_above[i] ? 0 : m_miss[i] + 1;
          if (m_miss[i] == rc[i]) begin
            m_det[i] = 1'b0; m_miss[i] = 0;
          end
        end
      end else begin
        m_acc[i] = s;
      end
    end
  endtask

  task automatic step();
    longint t0, t1;
    t0 = thr32;
    t1 = thr16;
    @(posedge clk);
    model_edge(0, t0);
    model_edge(1, t1);
    #1;
    chk("wv0", wv0, m_wv[0]);
    chk("ws0", ws0, m_ws[0]);
    chk("ab0", ab0, m_above[0]);
    chk("det0", det0, m_det[0]);
    chk("dp0", dp0, m_pulse[0]);
    chk("pc0", pc0, m_cnt[0]);
    chk("wv1", wv1, m_wv[1]);
    chk("ws1", ws1, m_ws[1]);
    chk("ab1", ab1, m_above[1]);
    chk("det1", det1, m_det[1]);
    chk("dp1", dp1, m_pulse[1]);
    chk("pc1", pc1, m_cnt[1]);
  endtask

  task automatic drive(input bit e, input bit p, input bit c, input int b);
    en = e; pv = p; clr = c; abs_sum = 12'(b);
    step();
  endtask

  task automatic window4(input int b);
    for (int k = 0; k < 4; k++) drive(1, 1, 0, b);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; clr = 1'b0; pv = 1'b0; abs_sum = '0;
    thr32 = 32'sd500; thr16 = 16'sd500;
    step();
    step();
    chk("rst_det", det0, 0);
    chk("rst_pc", pc0, 0);
    rst = 1'b0;

    // one window of 4x100 below 500, PeriodCount 1,2,3,0
    drive(1, 1, 0, 100); chk("pc_1", pc0, 1);
    drive(1, 1, 0, 100); chk("pc_2", pc0, 2);
    drive(1, 1, 0, 100); chk("pc_3", pc0, 3);
    drive(1, 1, 0, 100);
    chk("w400_ws", ws0, 400);
    chk("w400_wv", wv0, 1);
    chk("w400_ab", ab0, 0);
    chk("w400_pc", pc0, 0);

    // three windows above -> detect on the third
    window4(200); chk("hit1_det", det0, 0);
    window4(200); chk("hit2_det", det0, 0);
    window4(200);
    chk("hit3_det", det0, 1);
    chk("hit3_pulse", dp0, 1);
    // below, above, below, below -> release only on the last
    drive(1, 1, 0, 50);
    chk("pulse_1cyc", dp0, 0);
    drive(1, 1, 0, 50); drive(1, 1, 0, 50); drive(1, 1, 0, 50);
    chk("miss1_det", det0, 1);
    window4(200); chk("above_det", det0, 1);
    window4(50);  chk("miss1b_det", det0, 1);
    window4(50);  chk("miss2_det", det0, 0);

    // bubbles carrying nonzero data must not be accumulated
    drive(1, 1, 0, 10);
    drive(1, 0, 0, 999);
    drive(1, 1, 0, 20);
    drive(0, 1, 0, 777);
    drive(1, 1, 0, 30);
    drive(0, 0, 0, 555);
    drive(1, 1, 0, 40);
    chk("bubble_ws", ws0, 100);

    // go active again, then Clear with the 3rd beat of a window
    window4(200); window4(200); window4(200);
    chk("re_det", det0, 1);
    drive(1, 1, 0, 200);
    drive(1, 1, 0, 200);
    drive(1, 1, 1, 200);
    chk("clr_det", det0, 0);
    chk("clr_pulse", dp0, 0);
    chk("clr_pc", pc0, 0);
    window4(50);
    chk("after_clr_ws", ws0, 200);

    // saturation of the 16-bit instance
    drive(0, 0, 1, 0);
    thr16 = 16'sd32767;
    for (int k = 0; k < 32; k++) drive(1, 1, 0, 2048);
    chk("sat_ws", ws1, 32767);
    chk("sat_ab", ab1, 1);
    chk("sat_det", det1, 1);

    // non-positive threshold: an all-zero window still counts as above
    drive(0, 0, 1, 0);
    thr32 = 32'sd0;
    window4(0);
    chk("thr0_ab", ab0, 1);

    // randomized traffic, thresholds changing mid-window
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 15) == 0) thr32 = 32'($urandom_range(0, 9000)) - 32'sd1000;
      if ($urandom_range(0, 15) == 0) thr16 = 16'($urandom_range(0, 65535));
      rst = ($urandom_range(0, 499) == 0);
      en = ($urandom_range(0, 9) != 0);
      pv = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 299) == 0);
      abs_sum = 12'($urandom_range(0, 2048));
      step();
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
